rv_decode_stage: RTL and testbench

//  Registered RV32I instruction-decode stage between IF and EX, with a valid/ready handshake.

---
 rtl/rv_decode_stage.sv | 210 +++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - RV32I decode stage with main+skid output buffer
module rv_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rd_we,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } bundle_t;

    bundle_t            dec;
    bundle_t            main_q, main_d;
    bundle_t            skid_q, skid_d;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic [2:0]         fmt_raw;
    logic               bad_funct;
    logic               shift_imm;
    logic signed [31:0] imm32;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               accept;

    assign opc       = in_instr[6:0];
    assign f3        = in_instr[14:12];
    assign f7        = in_instr[31:25];
    assign shift_imm = (opc == OPC_OP_IMM) && (f3 == 3'b001 || f3 == 3'b101);

    always_comb begin
        fmt_raw   = FMT_ILL;
        bad_funct = 1'b0;
        imm32     = '0;
        unique case (opc)
            OPC_OP:                                       fmt_raw = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM,
            OPC_FENCE:                                    fmt_raw = FMT_I;
            OPC_STORE:                                    fmt_raw = FMT_S;
            OPC_BRANCH:                                   fmt_raw = FMT_B;
            OPC_LUI, OPC_AUIPC:                           fmt_raw = FMT_U;
            OPC_JAL:                                      fmt_raw = FMT_J;
            default:                                      fmt_raw = FMT_ILL;
        endcase

        if (opc == OPC_OP) begin
            if (f7 != 7'b0000000 && f7 != 7'b0100000)
                bad_funct = 1'b1;
            if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)
                bad_funct = 1'b1;
        end
        if (opc == OPC_OP_IMM && f3 == 3'b001 && f7 != 7'b0000000)
            bad_funct = 1'b1;
        if (opc == OPC_OP_IMM && f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
            bad_funct = 1'b1;

        case (fmt_raw)
            FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'b0};
            FMT_J:   imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Every field is assigned on every path, so an illegal word leaves nothing stale.
    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.opcode = opc;
        if (fmt_raw == FMT_ILL || bad_funct) begin
            dec.fmt     = FMT_ILL;
            dec.illegal = 1'b1;
        end else begin
            dec.fmt      = fmt_raw;
            dec.imm      = XLEN'(imm32);
            dec.rs1_used = (fmt_raw == FMT_R) || (fmt_raw == FMT_I) ||
                           (fmt_raw == FMT_S) || (fmt_raw == FMT_B);
            dec.rs2_used = (fmt_raw == FMT_R) || (fmt_raw == FMT_S) || (fmt_raw == FMT_B);
            if (dec.rs1_used) begin
                dec.rs1    = in_instr[19:15];
                dec.funct3 = f3;
            end
            if (dec.rs2_used)
                dec.rs2 = in_instr[24:20];
            if (fmt_raw == FMT_R || fmt_raw == FMT_I || fmt_raw == FMT_U || fmt_raw == FMT_J) begin
                dec.rd    = in_instr[11:7];
                dec.rd_we = (in_instr[11:7] != 5'd0);
            end
            if (fmt_raw == FMT_R || shift_imm)
                dec.funct7 = f7;
        end
    end

    assign accept = in_valid && !skid_valid_q;

    // Skid is only ever occupied while main is, so an empty main implies an empty skid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready     = !skid_valid_q;
    assign out_valid    = main_valid_q;
    assign out_pc       = main_q.pc;
    assign out_opcode   = main_q.opcode;
    assign out_rd       = main_q.rd;
    assign out_rs1      = main_q.rs1;
    assign out_rs2      = main_q.rs2;
    assign out_funct3   = main_q.funct3;
    assign out_funct7   = main_q.funct7;
    assign out_imm      = main_q.imm;
    assign out_fmt      = main_q.fmt;
    assign out_rd_we    = main_q.rd_we;
    assign out_rs1_used = main_q.rs1_used;
    assign out_rs2_used = main_q.rs2_used;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - self-checking bench for rv_decode_stage
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3, out_fmt;
    logic        out_rd_we, out_rs1_used, out_rs2_used, out_illegal;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used),
        .out_rs2_used(out_rs2_used), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        we, u1, u2, ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA tables, not from the RTL structure.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   f;
        int   imm;
        logic [6:0] op;
        logic [2:0] fn3;
        logic [6:0] fn7;
        op  = w[6:0];
        fn3 = w[14:12];
        fn7 = w[31:25];
        e = '{default: 0};
        e.pc  = pc;
        e.opc = op;
        if (op == 7'h33)                                         f = 0;
        else if (op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F})  f = 1;
        else if (op == 7'h23)                                    f = 2;
        else if (op == 7'h63)                                    f = 3;
        else if (op inside {7'h37, 7'h17})                       f = 4;
        else if (op == 7'h6F)                                    f = 5;
        else                                                     f = 7;
        if (f == 0 && !(fn7 inside {7'd0, 7'd32}))                 f = 7;
        if (f == 0 && fn7 == 7'd32 && !(fn3 inside {3'd0, 3'd5}))  f = 7;
        if (op == 7'h13 && fn3 == 3'd1 && fn7 != 7'd0)             f = 7;
        if (op == 7'h13 && fn3 == 3'd5 && !(fn7 inside {7'd0, 7'd32})) f = 7;
        e.fmt = 3'(f);
        if (f == 7) begin
            e.ill = 1'b1;
            return e;
        end
        case (f)
            1:       imm = $signed(w[31:20]);
            2:       imm = $signed({w[31:25], w[11:7]});
            3:       imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            4:       imm = {w[31:12], 12'h000};
            5:       imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: imm = 0;
        endcase
        e.imm = imm;
        e.u1  = (f <= 3);
        e.u2  = (f == 0 || f == 2 || f == 3);
        e.rs1 = e.u1 ? w[19:15] : 5'd0;
        e.f3  = e.u1 ? fn3 : 3'd0;
        e.rs2 = e.u2 ? w[24:20] : 5'd0;
        e.rd  = (f == 0 || f == 1 || f == 4 || f == 5) ? w[11:7] : 5'd0;
        e.we  = (e.rd != 5'd0);
        e.f7  = (f == 0 || (op == 7'h13 && (fn3 == 3'd1 || fn3 == 3'd5))) ? fn7 : 7'd0;
        return e;
    endfunction

    // Occupancy model: at most two held entries, FIFO order, flush empties it.
    always @(posedge clk or negedge rst_n) begin
        bit acc, drn;
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(model(in_instr, in_pc));
        end
    end

    always @(posedge clk)
        if (rst_n && !flush && out_valid && out_ready) got.push_back(out_pc);

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && chk_en) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            if (q.size() > 0 && out_valid) begin
                e = q[0];
                chk("pc", out_pc, e.pc);
                chk("opcode", out_opcode, e.opc);
                chk("rd", out_rd, e.rd);
                chk("rs1", out_rs1, e.rs1);
                chk("rs2", out_rs2, e.rs2);
                chk("funct3", out_funct3, e.f3);
                chk("funct7", out_funct7, e.f7);
                chk("imm", out_imm, e.imm);
                chk("fmt", out_fmt, e.fmt);
                chk("rd_we", out_rd_we, e.we);
                chk("rs1_used", out_rs1_used, e.u1);
                chk("rs2_used", out_rs2_used, e.u2);
                chk("illegal", out_illegal, e.ill);
            end
        end
    end

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        n = 0;
        do begin
            acc = in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            miscompares++;
            $display("FAIL offer_timeout: pc %0h not accepted within 50 cycles", pc);
        end
    endtask

    logic [31:0] stream[10] = '{
        32'hFFF00093, 32'h123452B7, 32'h0020A423, 32'h00000000, 32'h4000F033,
        32'h00208463, 32'h40105093, 32'h02101093, 32'h008000EF, 32'h00100073
    };

    initial begin
        exp_t m;
        int   n0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);

        m = model(32'hFFF00093, 0);
        chk("pin_addi_fmt", m.fmt, 1);
        chk("pin_addi_imm", m.imm, 32'hFFFFFFFF);
        chk("pin_addi_u2", m.u2, 0);
        m = model(32'h123452B7, 0);
        chk("pin_lui_imm", m.imm, 32'h12345000);
        chk("pin_lui_rd", m.rd, 5);
        m = model(32'h0020A423, 0);
        chk("pin_sw_fmt", m.fmt, 2);
        chk("pin_sw_imm", m.imm, 8);
        chk("pin_sw_we", m.we, 0);
        m = model(32'h00208463, 0);
        chk("pin_beq_imm", m.imm, 8);
        m = model(32'h4000F033, 0);
        chk("pin_ill_fmt", m.fmt, 7);
        chk("pin_ill_flag", m.ill, 1);
        m = model(32'h008000EF, 0);
        chk("pin_jal_imm", m.imm, 8);

        chk_en = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        chk("add_fmt", out_fmt, 0);
        chk("add_rd", out_rd, 3);
        chk("add_rs1", out_rs1, 1);
        chk("add_rs2", out_rs2, 2);
        chk("add_imm", out_imm, 0);
        chk("add_we", out_rd_we, 1);
        for (int i = 0; i < 10; i++) begin
            in_instr = stream[i];
            in_pc    = 32'h1000 + 32'(4 * i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        got.delete();
        out_ready = 1'b0;
        offer(32'h00308133, 32'h2000);
        offer(32'h00A00513, 32'h2004);
        in_instr = 32'h00B12023; in_pc = 32'h2008;
        repeat (2) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_main_pc", out_pc, 32'h2000);
        out_ready = 1'b1;
        offer(32'h00B12023, 32'h2008);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_order0", got[0], 32'h2000);
            chk("bp_order1", got[1], 32'h2004);
            chk("bp_order2", got[2], 32'h2008);
        end

        n0 = got.size();
        out_ready = 1'b0;
        offer(32'h00100093, 32'h3000);
        offer(32'h00200113, 32'h3004);
        in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h3008; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("fl_none_delivered", got.size(), n0);

        out_ready = 1'b0;
        offer(32'hFFF00093, 32'h4000);
        in_valid = 1'b0;
        chk("rs_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_out_valid", out_valid, 0);
        chk("rs_in_ready", in_ready, 1);
        chk("rs_out_pc", out_pc, 0);
        chk("rs_out_imm", out_imm, 0);
        chk("rs_out_fmt", out_fmt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_hold_pc", out_pc, 0);
        chk("rs_hold_opcode", out_opcode, 0);
        out_ready = 1'b1;
        offer(32'h123452B7, 32'h5000);
        in_valid = 1'b0;
        chk("rs_new_pc", out_pc, 32'h5000);
        chk("rs_new_imm", out_imm, 32'h12345000);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
